// File: rtl/framebuffer_reader_if.sv
// framebuffer_reader_if
//   Groups the two bus-like channels of the frame buffer reader:
//   - camera write channel: wr_valid / wr_addr / wr_data in, wr_ready out
//   - SP256K port: spram_addr / spram_di / spram_we out, spram_do in
//   slave  : the reader (owns the SPRAM port, accepts camera writes)
//   master : the environment (camera source + SPRAM macro)
interface framebuffer_reader_if;
   logic        wr_valid;
   logic [13:0] wr_addr;
   logic [15:0] wr_data;
   logic        wr_ready;
   logic [13:0] spram_addr;
   logic [15:0] spram_di;
   logic        spram_we;
   logic [15:0] spram_do;

   modport slave (
      input  wr_valid, wr_addr, wr_data, spram_do,
      output wr_ready, spram_addr, spram_di, spram_we
   );

   modport master (
      output wr_valid, wr_addr, wr_data, spram_do,
      input  wr_ready, spram_addr, spram_di, spram_we
   );
endinterface

// File: rtl/framebuffer_reader.sv
// framebuffer_reader
//   Sole owner of the single-port SP256K frame buffer. Reads RGB565 pixels in
//   step with the VGA timing generator, upscales by 2^SCALE_SHIFT, converts to
//   RGB222, and slips queued camera writes into cycles not used by the display.
// Ports:
//   i_clk, i_reset          pixel clock, synchronous active-high reset
//   i_vga_row/col/valid     current VGA position and visible-area flag
//   i_hsync_in/i_vsync_in   syncs from the timing generator
//   bus (slave)             camera write channel + SPRAM port
//   o_rgb                   {R[1:0],G[1:0],B[1:0]}, PIPE cycles after input
//   o_hsync_out/o_vsync_out syncs delayed by PIPE, aligned with o_rgb
//   o_drop_count            saturating count of writes refused while full
module framebuffer_reader #(
   parameter int IMG_W       = 128,
   parameter int IMG_H       = 96,
   parameter int SCALE_SHIFT = 2,
   parameter int X_OFFSET    = 64,
   parameter int Y_OFFSET    = 48,
   parameter int PIPE        = 3
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [9:0]           i_vga_row,
   input  logic [9:0]           i_vga_col,
   input  logic                 i_vga_valid,
   input  logic                 i_hsync_in,
   input  logic                 i_vsync_in,
   framebuffer_reader_if.slave  bus,
   output logic [5:0]           o_rgb,
   output logic                 o_hsync_out,
   output logic                 o_vsync_out,
   output logic [7:0]           o_drop_count
);
   localparam int LOG_W = $clog2(IMG_W);
   localparam int X_END = X_OFFSET + (IMG_W << SCALE_SHIFT);
   localparam int Y_END = Y_OFFSET + (IMG_H << SCALE_SHIFT);
   localparam int NPIX  = IMG_W * IMG_H;

   // window / address computation on the incoming position
   logic [9:0]  w_dx, w_dy;
   logic        w_in_win, w_slot;
   logic [13:0] w_rd_addr;

   assign w_dx = i_vga_col - 10'(X_OFFSET);
   assign w_dy = i_vga_row - 10'(Y_OFFSET);
   assign w_in_win = i_vga_valid
                   && ({1'b0, i_vga_col} >= 11'(X_OFFSET)) && ({1'b0, i_vga_col} < 11'(X_END))
                   && ({1'b0, i_vga_row} >= 11'(Y_OFFSET)) && ({1'b0, i_vga_row} < 11'(Y_END));
   // one fetch per group of 2^SCALE_SHIFT output pixels
   assign w_slot    = w_in_win && (w_dx[SCALE_SHIFT-1:0] == '0);
   // IMG_W is a power of two: y*IMG_W is a shift
   assign w_rd_addr = (14'(w_dy >> SCALE_SHIFT) << LOG_W) + 14'(w_dx >> SCALE_SHIFT);

   // delay lines and display state
   logic [PIPE-1:0] r_hs_pipe, r_vs_pipe, r_win_pipe;
   logic [PIPE-2:0] r_slot_pipe;
   logic [15:0]     r_pix_hold;

   // 2-entry write FIFO
   logic [13:0] r_fifo_addr [2];
   logic [15:0] r_fifo_data [2];
   logic        r_wptr, r_rptr;
   logic [1:0]  r_count;
   logic [7:0]  r_drop;

   // registered SPRAM port
   logic [13:0] r_sp_addr;
   logic [15:0] r_sp_di;
   logic        r_sp_we;

   logic w_ready, w_push, w_pop, w_head_ok;

   assign w_ready   = (r_count != 2'd2);
   assign w_push    = bus.wr_valid && w_ready;
   // the display read owns the port on a read slot; the FIFO holds
   assign w_pop     = !w_slot && (r_count != 2'd0);
   assign w_head_ok = r_fifo_addr[r_rptr] < 14'(NPIX);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_hs_pipe   <= '0;
         r_vs_pipe   <= '0;
         r_win_pipe  <= '0;
         r_slot_pipe <= '0;
         r_pix_hold  <= '0;
         r_wptr      <= 1'b0;
         r_rptr      <= 1'b0;
         r_count     <= 2'd0;
         r_drop      <= 8'd0;
         r_sp_addr   <= '0;
         r_sp_di     <= '0;
         r_sp_we     <= 1'b0;
      end else begin
         r_hs_pipe   <= {r_hs_pipe[PIPE-2:0], i_hsync_in};
         r_vs_pipe   <= {r_vs_pipe[PIPE-2:0], i_vsync_in};
         r_win_pipe  <= {r_win_pipe[PIPE-2:0], w_in_win};
         r_slot_pipe <= {r_slot_pipe[PIPE-3:0], w_slot};

         // address goes onto the port on the first edge, SPRAM returns data
         // on the second, so the capture lands on the third edge with rgb
         if (r_slot_pipe[PIPE-2])
            r_pix_hold <= bus.spram_do;

         if (w_push) begin
            r_fifo_addr[r_wptr] <= bus.wr_addr;
            r_fifo_data[r_wptr] <= bus.wr_data;
            r_wptr              <= ~r_wptr;
         end
         if (w_pop)
            r_rptr <= ~r_rptr;
         r_count <= r_count + 2'(w_push) - 2'(w_pop);

         if (bus.wr_valid && !w_ready && (r_drop != 8'hFF))
            r_drop <= r_drop + 8'd1;

         if (w_slot) begin
            r_sp_addr <= w_rd_addr;
            r_sp_we   <= 1'b0;
         end else if (w_pop && w_head_ok) begin
            r_sp_addr <= r_fifo_addr[r_rptr];
            r_sp_di   <= r_fifo_data[r_rptr];
            r_sp_we   <= 1'b1;
         end else begin
            // idle or out-of-range entry discarded: port holds, no write
            r_sp_we   <= 1'b0;
         end
      end
   end

   assign bus.wr_ready   = w_ready;
   assign bus.spram_addr = r_sp_addr;
   assign bus.spram_di   = r_sp_di;
   assign bus.spram_we   = r_sp_we;

   assign o_rgb        = r_win_pipe[PIPE-1] ? {r_pix_hold[15:14], r_pix_hold[10:9], r_pix_hold[4:3]} : 6'd0;
   assign o_hsync_out  = r_hs_pipe[PIPE-1];
   assign o_vsync_out  = r_vs_pipe[PIPE-1];
   assign o_drop_count = r_drop;
endmodule

// File: tb/tb_framebuffer_reader.sv
module tb_framebuffer_reader;
   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] row, col;
   logic       valid, hs, vs;
   logic [5:0] rgb;
   logic       hso, vso;
   logic [7:0] drop;

   always #20 clk = ~clk;

   framebuffer_reader_if bus ();

   framebuffer_reader dut (
      .i_clk(clk), .i_reset(reset),
      .i_vga_row(row), .i_vga_col(col), .i_vga_valid(valid),
      .i_hsync_in(hs), .i_vsync_in(vs),
      .bus(bus),
      .o_rgb(rgb), .o_hsync_out(hso), .o_vsync_out(vso),
      .o_drop_count(drop)
   );

   // SP256K model: read-first, data one cycle after address
   logic [15:0] mem [0:16383];
   always @(posedge clk) begin
      if (reset) begin
         mem[0] <= 16'hF800;
         mem[1] <= 16'h07E0;
      end else if (bus.spram_we) begin
         mem[bus.spram_addr] <= bus.spram_di;
      end
      bus.spram_do <= mem[bus.spram_addr];
   end

   typedef struct packed { logic [13:0] a; logic [15:0] d; } wr_t;

   int         total = 0, bad = 0;
   wr_t        mq[$];        // model FIFO contents
   logic [7:0] pq[$];        // expected {rgb,hsync,vsync}
   logic       m_we = 1'b0;
   wr_t        m_w;
   logic [7:0] m_drop = 8'd0;
   int         m_refuse = 0;

   function automatic logic f_slot();
      int c, r;
      logic w;
      c = int'(col);
      r = int'(row);
      w = valid && c >= 64 && c < 576 && r >= 48 && r < 432;
      return w && ((c - 64) % 4 == 0);
   endfunction

   // advance one clock edge, updating the write-side model with the inputs
   // that the DUT samples on that edge
   task automatic cycle();
      int  n;
      wr_t t;
      logic slot;
      slot = f_slot();
      if (reset) begin
         mq.delete();
         m_we = 1'b0;
         m_drop = 8'd0;
      end else begin
         n = mq.size();
         m_we = 1'b0;
         if (!slot && n > 0) begin
            m_w = mq.pop_front();
            m_we = (m_w.a < 14'd12288);
         end
         if (bus.wr_valid && n < 2) begin
            t.a = bus.wr_addr;
            t.d = bus.wr_data;
            mq.push_back(t);
         end
         if (bus.wr_valid && n == 2) begin
            m_refuse++;
            if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         total++;
         if (bus.wr_ready !== 1'b1 || bus.spram_we !== 1'b0 || rgb !== 6'd0 || drop !== 8'd0) begin
            bad++;
            $display("FAIL reset_hold: got rdy=%b we=%b rgb=%b drop=%0d, want rdy=1 we=0 rgb=0 drop=0",
                     bus.wr_ready, bus.spram_we, rgb, drop);
         end
         cycle();
      end
      reset = 1'b0;
      bus.wr_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         total++;
         if (bus.spram_we !== 1'b0 || bus.wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: got we=%b rdy=%b, want we=0 rdy=1", bus.spram_we, bus.wr_ready);
         end
      end
   endtask

   task automatic test_pixels();
      logic [7:0] e;
      logic [5:0] x;
      row = 10'd48;
      for (int i = 0; i < 10; i++) begin
         if (i < 8) begin
            col = 10'(64 + i);
            valid = 1'b1;
            x = (i < 4) ? 6'b110000 : 6'b001100;
         end else begin
            valid = 1'b0;
            x = 6'd0;
         end
         hs = i[0];
         vs = i[1];
         pq.push_back({x, hs, vs});
         cycle();
         if (i >= 2) begin
            e = pq.pop_front();
            total++;
            if ({rgb, hso, vso} !== e) begin
               bad++;
               $display("FAIL pixel_col%0d: got rgb=%b hs=%b vs=%b, want rgb=%b hs=%b vs=%b",
                        i - 2, rgb, hso, vso, e[7:2], e[1], e[0]);
            end
         end
      end
      pq.delete();
   endtask

   task automatic test_window_sync();
      logic [9:0] rows [6] = '{10'd48, 10'd48, 10'd100, 10'd200, 10'd47, 10'd432};
      logic [9:0] cols [6] = '{10'd63, 10'd576, 10'd200, 10'd70, 10'd64, 10'd64};
      logic       vals [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic       hss  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic       vss  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [7:0] e;
      for (int i = 0; i < 8; i++) begin
         if (i < 6) begin
            row = rows[i]; col = cols[i]; valid = vals[i]; hs = hss[i]; vs = vss[i];
         end else begin
            valid = 1'b0; hs = 1'b0; vs = 1'b0;
         end
         pq.push_back({6'd0, hs, vs});
         cycle();
         if (i >= 2) begin
            e = pq.pop_front();
            total++;
            if ({rgb, hso, vso} !== e) begin
               bad++;
               $display("FAIL window_sync_%0d: got rgb=%b hs=%b vs=%b, want rgb=%b hs=%b vs=%b",
                        i - 2, rgb, hso, vso, e[7:2], e[1], e[0]);
            end
         end
      end
      pq.delete();
      hs = 1'b0; vs = 1'b0;
   endtask

   task automatic test_writes_idle();
      int nw = 0;
      valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus.wr_valid = (i < 4);
         bus.wr_addr  = 14'(100 + i);
         bus.wr_data  = 16'hA500 + 16'(i);
         cycle();
         if (bus.spram_we === 1'b1) nw++;
         total++;
         if (bus.spram_we !== m_we || (m_we && (bus.spram_addr !== m_w.a || bus.spram_di !== m_w.d))) begin
            bad++;
            $display("FAIL idle_write_%0d: got we=%b a=%0d d=%h, want we=%b a=%0d d=%h",
                     i, bus.spram_we, bus.spram_addr, bus.spram_di, m_we, m_w.a, m_w.d);
         end
         total++;
         if (bus.wr_ready !== 1'b1 || drop !== 8'd0) begin
            bad++;
            $display("FAIL idle_ready_%0d: got rdy=%b drop=%0d, want rdy=1 drop=0", i, bus.wr_ready, drop);
         end
      end
      total++;
      if (nw != 4) begin
         bad++;
         $display("FAIL idle_write_count: got %0d, want 4", nw);
      end
   endtask

   task automatic test_out_of_range();
      logic [7:0] d0;
      int nw = 0;
      valid = 1'b0;
      d0 = m_drop;
      for (int i = 0; i < 7; i++) begin
         bus.wr_valid = (i == 0 || i == 2);
         bus.wr_addr  = (i == 0) ? 14'd12288 : 14'd5;
         bus.wr_data  = (i == 0) ? 16'hFFFF : 16'h1234;
         if (bus.wr_valid) begin
            total++;
            if (bus.wr_ready !== 1'b1) begin
               bad++;
               $display("FAIL oor_handshake_%0d: got rdy=%b, want 1", i, bus.wr_ready);
            end
         end
         cycle();
         if (bus.spram_we === 1'b1) nw++;
         total++;
         if (bus.spram_we !== m_we || (m_we && (bus.spram_addr !== m_w.a || bus.spram_di !== m_w.d))) begin
            bad++;
            $display("FAIL oor_write_%0d: got we=%b a=%0d d=%h, want we=%b a=%0d d=%h",
                     i, bus.spram_we, bus.spram_addr, bus.spram_di, m_we, m_w.a, m_w.d);
         end
      end
      total++;
      if (nw != 1 || mem[5] !== 16'h1234 || drop !== d0) begin
         bad++;
         $display("FAIL oor_result: got writes=%0d mem5=%h drop=%0d, want writes=1 mem5=1234 drop=%0d",
                  nw, mem[5], drop, d0);
      end
   endtask

   task automatic test_back_to_back();
      int  i = 0;
      logic seen_full = 1'b0;
      m_refuse = 0;
      row = 10'd48;
      valid = 1'b1;
      bus.wr_valid = 1'b1;
      while (i < 3000 && m_refuse < 300) begin
         col = 10'(64 + (i % 256));
         bus.wr_addr = 14'(200 + (i % 50));
         bus.wr_data = 16'(i);
         cycle();
         if (bus.wr_ready === 1'b0) seen_full = 1'b1;
         total++;
         if (bus.spram_we !== m_we || (m_we && (bus.spram_addr !== m_w.a || bus.spram_di !== m_w.d))
             || bus.wr_ready !== (mq.size() < 2) || drop !== m_drop) begin
            bad++;
            if (bad < 20)
               $display("FAIL bp_cycle_%0d: got we=%b a=%0d d=%h rdy=%b drop=%0d, want we=%b a=%0d d=%h rdy=%b drop=%0d",
                        i, bus.spram_we, bus.spram_addr, bus.spram_di, bus.wr_ready, drop,
                        m_we, m_w.a, m_w.d, (mq.size() < 2), m_drop);
         end
         i++;
      end
      total++;
      if (m_refuse < 300 || !seen_full || drop !== 8'd255) begin
         bad++;
         $display("FAIL bp_saturate: got refusals=%0d full_seen=%b drop=%0d, want >=300 1 255",
                  m_refuse, seen_full, drop);
      end
      bus.wr_valid = 1'b0;
      valid = 1'b0;
      for (int k = 0; k < 4; k++) cycle();
   endtask

   initial begin
      reset = 1'b1;
      row = '0; col = '0; valid = 1'b0; hs = 1'b0; vs = 1'b0;
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 14'd7;
      bus.wr_data  = 16'h0001;
      test_reset();
      test_pixels();
      test_window_sync();
      test_writes_idle();
      test_out_of_range();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
